// File: rtl/hamming_enc_sched_if.sv
// hamming_enc_sched_if
//   Bundles the requester handshake, shift enable and serial/codeword
//   outputs of the Hamming(15,11) transmit scheduler.
//   master : requester/sink side (drives en, req0/1, data0/1)
//   slave  : scheduler side (drives ack0/1, ser_bit, ser_valid, cw_out,
//            write, busy)
interface hamming_enc_sched_if;
   logic        en;
   logic        req0;
   logic        req1;
   logic [10:0] data0;
   logic [10:0] data1;
   logic        ack0;
   logic        ack1;
   logic        ser_bit;
   logic        ser_valid;
   logic [14:0] cw_out;
   logic        write;
   logic        busy;

   modport master (
      output en, req0, req1, data0, data1,
      input  ack0, ack1, ser_bit, ser_valid, cw_out, write, busy
   );

   modport slave (
      input  en, req0, req1, data0, data1,
      output ack0, ack1, ser_bit, ser_valid, cw_out, write, busy
   );
endinterface

// File: rtl/hamming_enc_sched.sv
// hamming_enc_sched
//   Round-robin scheduler and serializer for the Hamming(15,11) transmit
//   path. A granted 11-bit word is encoded (even parity at positions
//   1, 2, 4, 8) into cw_out and shifted out LSB (position 1) first under a
//   15-step counter; write pulses with the last bit.
// Ports
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : hamming_enc_sched_if.slave
//           en (shift enable), req0/req1 + data0/data1 (requesters),
//           ack0/ack1 (registered grant pulse), ser_bit/ser_valid,
//           cw_out (bit i = code position i+1), write, busy
module hamming_enc_sched (
   input  logic                      clk,
   input  logic                      reset,
   hamming_enc_sched_if.slave        bus
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic        r_last;
   logic [14:0] r_cw;
   logic        r_ack0;
   logic        r_ack1;

   logic        w_capture;
   logic        w_gnt1;
   logic        w_ser_bit;
   logic        w_ser_valid;
   logic        w_write;
   logic        w_busy;
   logic [10:0] w_data;

   // Codeword layout {pos15..pos1}: data fills the non-power-of-two slots.
   function automatic logic [14:0] encode(input logic [10:0] d);
      logic p1, p2, p4, p8;
      p1 = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10];
      p2 = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[10];
      p4 = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
      p8 = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[10];
      return {d[10:4], p8, d[3:1], p4, d[0], p2, p1};
   endfunction

   // Requester 1 wins when alone, or when both ask and 1 was not last.
   assign w_gnt1 = bus.req1 & (~bus.req0 | ~r_last);
   assign w_data = w_gnt1 ? bus.data1 : bus.data0;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_capture   = 1'b0;
      w_ser_bit   = 1'b0;
      w_ser_valid = 1'b0;
      w_write     = 1'b0;
      w_busy      = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.req0 | bus.req1) begin
               w_capture   = 1'b1;
               w_cnt_nxt   = '0;
               w_state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            w_busy      = 1'b1;
            w_ser_valid = bus.en;
            w_ser_bit   = r_cw[r_cnt];
            if (bus.en) begin
               if (r_cnt == 4'd14) begin
                  w_write     = 1'b1;
                  w_cnt_nxt   = '0;
                  w_state_nxt = IDLE;
               end else begin
                  w_cnt_nxt = r_cnt + 4'd1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_last  <= 1'b1;
         r_cw    <= '0;
         r_ack0  <= 1'b0;
         r_ack1  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ack0  <= w_capture & ~w_gnt1;
         r_ack1  <= w_capture & w_gnt1;
         if (w_capture) begin
            r_last <= w_gnt1;
            r_cw   <= encode(w_data);
         end
      end
   end

   assign bus.ack0      = r_ack0;
   assign bus.ack1      = r_ack1;
   assign bus.cw_out    = r_cw;
   assign bus.ser_bit   = w_ser_bit;
   assign bus.ser_valid = w_ser_valid;
   assign bus.write     = w_write;
   assign bus.busy      = w_busy;

endmodule

// File: tb/tb_hamming_enc_sched.sv
// tb_hamming_enc_sched
//   Self-checking bench for hamming_enc_sched. Inputs are driven 1 time
//   unit after the rising edge, outputs sampled on the falling edge. The
//   reference model builds codewords position by position and predicts
//   round-robin grants from a single "last granted" bit.
module tb_hamming_enc_sched;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_chk = 0;
   int   n_err = 0;
   bit   m_last;

   hamming_enc_sched_if bus ();

   hamming_enc_sched dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2ms;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [14:0] model_enc(input logic [10:0] d);
      int dpos[11] = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
      int pw[4]    = '{1, 2, 4, 8};
      logic [14:0] cw;
      logic        par;
      cw = '0;
      for (int j = 0; j < 11; j++) cw[dpos[j]-1] = d[j];
      for (int k = 0; k < 4; k++) begin
         par = 1'b0;
         for (int p = 1; p <= 15; p++)
            if (((p & pw[k]) != 0) && (p != pw[k])) par ^= cw[p-1];
         cw[pw[k]-1] = par;
      end
      return cw;
   endfunction

   function automatic int syndrome(input logic [14:0] v);
      int s = 0;
      for (int i = 0; i < 15; i++) if (v[i]) s ^= (i + 1);
      return s;
   endfunction

   function automatic int predict_grant(input bit r0, input bit r1);
      int g;
      if (r0 && r1) g = m_last ? 0 : 1;
      else          g = r1 ? 1 : 0;
      m_last = (g == 1);
      return g;
   endfunction

   // ---------------- word driver / monitor ----------------
   int          o_gid, o_nbits, o_lat_ack, o_lat_wr, o_nwrite, o_nack;
   int          o_inval, o_ack_cyc, o_wr_idx;
   bit          o_both;
   logic [14:0] o_bits, o_cw;

   task automatic send(input bit r0, input bit r1, input logic [10:0] d0,
                       input logic [10:0] d1, input bit hold,
                       input int stall_at, input int stall_len);
      bit pend;
      int stalled;
      o_gid = -1; o_nbits = 0; o_lat_ack = -1; o_lat_wr = -1; o_nwrite = 0;
      o_nack = 0; o_inval = 0; o_ack_cyc = 0; o_wr_idx = -1; o_both = 0;
      o_bits = '0; o_cw = 'x; pend = 0; stalled = 0;
      @(posedge clk); #1;
      bus.req0 = r0; bus.req1 = r1; bus.data0 = d0; bus.data1 = d1; bus.en = 1'b1;
      for (int i = 1; i <= 60; i++) begin
         @(posedge clk); #1;
         if (pend) begin
            if (!hold) begin
               if (o_gid == 0) bus.req0 = 1'b0;
               else            bus.req1 = 1'b0;
            end
            pend = 0;
         end
         bus.en = !(o_nbits == stall_at && stalled < stall_len);
         if (!bus.en) stalled++;
         @(negedge clk);
         if (bus.ack0 && bus.ack1) o_both = 1;
         if (bus.ack0 || bus.ack1) begin
            o_nack++;
            if (o_gid < 0) begin
               o_gid = bus.ack1 ? 1 : 0;
               o_lat_ack = i; o_ack_cyc = cyc; o_cw = bus.cw_out; pend = 1;
            end
         end
         if (bus.busy && !bus.ser_valid) o_inval++;
         if (bus.ser_valid) begin
            if (o_nbits < 15) o_bits[o_nbits] = bus.ser_bit;
            o_nbits++;
         end
         if (bus.write) begin
            o_nwrite++; o_lat_wr = i; o_wr_idx = o_nbits;
            break;
         end
      end
      bus.en = 1'b1;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; bus.req0 = 1'b0; bus.req1 = 1'b0; bus.en = 1'b0;
      bus.data0 = '0; bus.data1 = '0;
      @(posedge clk); @(negedge clk);
      reset = 1'b0;
      m_last = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [20:0] obs;
      reset = 1'b1; bus.req0 = 1'b0; bus.req1 = 1'b0; bus.en = 1'b0;
      bus.data0 = '0; bus.data1 = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      obs = {bus.ack0, bus.ack1, bus.ser_bit, bus.ser_valid, bus.write, bus.busy, bus.cw_out};
      n_chk++;
      if (obs !== 21'h0) begin
         n_err++; $display("FAIL reset_outputs got=%h exp=%h", obs, 21'h0);
      end
      reset = 1'b0;
      m_last = 1'b1;
   endtask

   task automatic test_basic();
      int g;
      g = predict_grant(1, 0);
      send(1, 0, 11'h001, 11'h555, 0, 99, 0);
      n_chk++; if (o_gid !== g) begin n_err++; $display("FAIL basic_grant got=%0d exp=%0d", o_gid, g); end
      n_chk++; if (o_lat_ack !== 1) begin n_err++; $display("FAIL basic_ack_latency got=%0d exp=1", o_lat_ack); end
      n_chk++; if (o_cw !== 15'h0007) begin n_err++; $display("FAIL basic_cw got=%h exp=0007", o_cw); end
      n_chk++; if (o_bits !== 15'h0007) begin n_err++; $display("FAIL basic_serial got=%h exp=0007", o_bits); end
      n_chk++; if (o_nbits !== 15) begin n_err++; $display("FAIL basic_nbits got=%0d exp=15", o_nbits); end
      n_chk++; if (o_lat_wr !== 15) begin n_err++; $display("FAIL basic_write_latency got=%0d exp=15", o_lat_wr); end
      n_chk++; if (o_wr_idx !== 15) begin n_err++; $display("FAIL basic_write_bit got=%0d exp=15", o_wr_idx); end
      n_chk++; if (o_nack !== 1) begin n_err++; $display("FAIL basic_ack_count got=%0d exp=1", o_nack); end
   endtask

   task automatic test_patterns();
      int g;
      g = predict_grant(0, 1);
      send(0, 1, 11'h2AA, 11'h7FF, 0, 99, 0);
      n_chk++; if (o_gid !== g) begin n_err++; $display("FAIL ones_grant got=%0d exp=%0d", o_gid, g); end
      n_chk++; if (o_cw !== 15'h7FFF) begin n_err++; $display("FAIL ones_cw got=%h exp=7fff", o_cw); end
      n_chk++; if (o_bits !== 15'h7FFF) begin n_err++; $display("FAIL ones_serial got=%h exp=7fff", o_bits); end
      g = predict_grant(1, 0);
      send(1, 0, 11'h000, 11'h7FF, 0, 99, 0);
      n_chk++; if (o_cw !== 15'h0000) begin n_err++; $display("FAIL zero_cw got=%h exp=0000", o_cw); end
      n_chk++; if (o_bits !== 15'h0000 || o_nbits !== 15) begin
         n_err++; $display("FAIL zero_serial got=%h/%0d exp=0000/15", o_bits, o_nbits);
      end
   endtask

   task automatic test_round_robin();
      logic [10:0] d0, d1;
      int          exp_seq[4] = '{0, 1, 0, 1};
      int          prev_cyc;
      int          g;
      do_reset();
      d0 = 11'($urandom); d1 = 11'($urandom);
      prev_cyc = 0;
      for (int k = 0; k < 4; k++) begin
         g = predict_grant(1, 1);
         send(1, 1, d0, d1, 1, 99, 0);
         n_chk++; if (o_gid !== exp_seq[k] || g != exp_seq[k]) begin
            n_err++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", k, o_gid, exp_seq[k]);
         end
         n_chk++; if (o_nack !== 1 || o_both !== 1'b0) begin
            n_err++; $display("FAIL rr_single_ack[%0d] got=%0d both=%0b exp=1 both=0", k, o_nack, o_both);
         end
         n_chk++; if (o_cw !== model_enc(g == 0 ? d0 : d1)) begin
            n_err++; $display("FAIL rr_cw[%0d] got=%h exp=%h", k, o_cw, model_enc(g == 0 ? d0 : d1));
         end
         if (k > 0) begin
            n_chk++; if (o_ack_cyc - prev_cyc !== 16) begin
               n_err++; $display("FAIL rr_spacing[%0d] got=%0d exp=16", k, o_ack_cyc - prev_cyc);
            end
         end
         prev_cyc = o_ack_cyc;
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;
   endtask

   task automatic test_stall();
      logic [10:0] d;
      logic [14:0] ref_bits;
      int          g;
      d = 11'($urandom);
      g = predict_grant(1, 0);
      send(1, 0, d, 11'h0, 0, 99, 0);
      ref_bits = o_bits;
      g = predict_grant(1, 0);
      send(1, 0, d, 11'h0, 0, 5, 3);
      n_chk++; if (o_lat_wr !== 18) begin n_err++; $display("FAIL stall_write_latency got=%0d exp=18", o_lat_wr); end
      n_chk++; if (o_inval !== 3) begin n_err++; $display("FAIL stall_invalid_cycles got=%0d exp=3", o_inval); end
      n_chk++; if (o_bits !== model_enc(d) || o_bits !== ref_bits || o_nbits !== 15) begin
         n_err++; $display("FAIL stall_bits got=%h/%0d exp=%h/15", o_bits, o_nbits, model_enc(d));
      end
      n_chk++; if (o_nwrite !== 1) begin n_err++; $display("FAIL stall_write_count got=%0d exp=1", o_nwrite); end
   endtask

   task automatic test_reset_mid_shift();
      logic [10:0] d;
      logic [20:0] obs;
      int          k, extra, g;
      bit          acked;
      d = 11'($urandom);
      k = 0; acked = 0;
      @(posedge clk); #1;
      bus.req0 = 1'b1; bus.req1 = 1'b0; bus.data0 = d; bus.en = 1'b1;
      for (int i = 0; i < 40 && k < 9; i++) begin
         @(posedge clk); #1;
         if (acked) bus.req0 = 1'b0;
         @(negedge clk);
         if (bus.ack0) acked = 1;
         if (bus.ser_valid) k++;
      end
      n_chk++; if (k !== 9) begin n_err++; $display("FAIL rstmid_reach_cnt9 got=%0d exp=9", k); end
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      obs = {bus.ack0, bus.ack1, bus.ser_bit, bus.ser_valid, bus.write, bus.busy, bus.cw_out};
      n_chk++; if (obs !== 21'h0) begin n_err++; $display("FAIL rstmid_outputs got=%h exp=%h", obs, 21'h0); end
      bus.req0 = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      m_last = 1'b1;
      extra = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.write || bus.busy || bus.ser_valid) extra++;
      end
      n_chk++; if (extra !== 0) begin n_err++; $display("FAIL rstmid_no_resend got=%0d exp=0", extra); end
      d = 11'($urandom);
      g = predict_grant(1, 0);
      send(1, 0, d, 11'h0, 0, 99, 0);
      n_chk++; if (o_gid !== g || o_bits !== model_enc(d) || o_lat_wr !== 15) begin
         n_err++; $display("FAIL rstmid_restart got=%0d/%h/%0d exp=%0d/%h/15", o_gid, o_bits, o_lat_wr, g, model_enc(d));
      end
   endtask

   task automatic test_random();
      logic [10:0] d0, d1;
      logic [14:0] exp_cw;
      bit          r0, r1;
      int          sel, sat, slen, exp_lat, g;
      for (int n = 0; n < 200; n++) begin
         sel = $urandom_range(1, 3);
         r0 = sel[0]; r1 = sel[1];
         d0 = 11'($urandom); d1 = 11'($urandom);
         sat = $urandom_range(0, 20); slen = $urandom_range(0, 3);
         exp_lat = 15 + ((sat <= 14) ? slen : 0);
         g = predict_grant(r0, r1);
         exp_cw = model_enc(g == 0 ? d0 : d1);
         send(r0, r1, d0, d1, 0, sat, slen);
         n_chk++; if (o_gid !== g || o_both !== 1'b0) begin
            n_err++; $display("FAIL rand_grant[%0d] got=%0d both=%0b exp=%0d", n, o_gid, o_both, g);
         end
         n_chk++; if (o_cw !== exp_cw) begin n_err++; $display("FAIL rand_cw[%0d] got=%h exp=%h", n, o_cw, exp_cw); end
         n_chk++; if (o_bits !== o_cw || o_nbits !== 15) begin
            n_err++; $display("FAIL rand_serial[%0d] got=%h/%0d exp=%h/15", n, o_bits, o_nbits, o_cw);
         end
         n_chk++; if (o_lat_wr !== exp_lat || o_nwrite !== 1) begin
            n_err++; $display("FAIL rand_write[%0d] got=%0d/%0d exp=%0d/1", n, o_lat_wr, o_nwrite, exp_lat);
         end
         n_chk++; if (syndrome(o_cw) !== 0) begin
            n_err++; $display("FAIL rand_syndrome[%0d] got=%0d exp=0", n, syndrome(o_cw));
         end
         for (int b = 0; b < 15; b++) begin
            logic [14:0] flip;
            flip = o_cw;
            flip[b] = ~flip[b];
            n_chk++; if (syndrome(flip) !== b + 1) begin
               n_err++; $display("FAIL rand_flip[%0d][%0d] got=%0d exp=%0d", n, b, syndrome(flip), b + 1);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_patterns();
      test_round_robin();
      test_stall();
      test_reset_mid_shift();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/hamming_enc_sched.md
# hamming_enc_sched

Scheduler and serializer for the Hamming(15,11) transmit path. It takes 11-bit data words from two requesters and arbitrates between them round-robin. It computes the 4 parity bits for the granted word and shifts the 15-bit codeword out serially under a 15-step bit counter. On the last bit it pulses `write`, which strobes the downstream codeword store.

## Interface
- Parameters: none. The code is fixed at Hamming(15,11), with parity at positions 1, 2, 4 and 8.
- `clk`  in  1  clock; all state is updated on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `en`  in  1  shift enable; when low, the SHIFT state stalls.
- `req0`, `req1`  in  1 each  requester word-available. Each requester holds its `req` and data stable until it sees its `ack`.
- `data0`, `data1`  in  11 each  requester data, `d[10:0]`.
- `ack0`, `ack1`  out  1 each  registered one-cycle grant/capture pulse.
- `ser_bit`  out  1  serial codeword bit.
- `ser_valid`  out  1  `ser_bit` is valid this cycle.
- `cw_out`  out  15  registered codeword. Bit i carries code position i+1.
- `write`  out  1  one-cycle pulse, high with the last serial bit.
- `busy`  out  1  high in SHIFT.

## Operation
- The FSM has two states:
  - IDLE: no word is being shifted.
  - SHIFT: a codeword is being sent; a 4-bit counter `cnt` steps through 0..14.
- Codeword mapping: `d[0]..d[10]` are placed at positions 3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15, in that order. Parity is even:
  - p1 = XOR of positions {3,5,7,9,11,13,15}
  - p2 = XOR of positions {3,6,7,10,11,14,15}
  - p4 = XOR of positions {5,6,7,12,13,14,15}
  - p8 = XOR of positions {9..15}
- Arbitration is round-robin with a 1-bit pointer `last`. Reset value of `last` is 1, so `req0` wins the first contest.
  - Both requests high: grant the requester that is not `last`.
  - One request high: grant it.
  - Update `last` on every grant.
- IDLE, at an edge with any `req`:
  - Capture the granted data and load `cw_out` with its encoded codeword.
  - Set the matching `ack` for the next cycle.
  - Clear `cnt` to 0 and go to SHIFT.
- SHIFT: `ser_valid` = `en`; `ser_bit` = `cw_out[cnt]`, so position 1 is sent first.
  - At an edge with `en` = 1: if `cnt` = 14, clear `cnt` to 0 and go to IDLE; otherwise `cnt` increments.
  - With `en` = 0: `cnt` holds.
- `write` = (state == SHIFT) and `en` and (`cnt` == 14). It is decoded from registered state, so there is no glitch path from the request inputs.
- No new capture happens in SHIFT. Requests wait and are evaluated again in IDLE.

## Timing
- Reset values (asynchronous):
  - state = IDLE, `cnt` = 0, `last` = 1.
  - `cw_out` = 0, `ack0` = `ack1` = 0.
  - `ser_valid` = 0, `write` = 0, `busy` = 0.
- Latency:
  - Request sampled at edge N.
  - `ack` and `busy` are high in cycle N+1.
  - The first bit is valid in cycle N+1 when `en` = 1.
  - The last bit and `write` come in cycle N+15 if `en` is held high.
- Throughput: one IDLE cycle follows each word, so back-to-back words take 16 cycles each.
- Stall: `en` low for k cycles in SHIFT delays the last bit and `write` by exactly k cycles. No bit is skipped or repeated.
- Simultaneous requests: exactly one `ack` per grant; the two acks are never high together.
- Requester handshake: a requester must deassert `req` at the edge after its `ack`. A `req` still high when the block next reaches IDLE is treated as a new word.
- Reset mid-SHIFT: the current word is discarded with no `write`, outputs go to their reset values immediately, and the word is not re-sent.

## Test plan
- Reset then `req0` = 1 with `data0` = 11'h001, `en` = 1:
  - `ack0` high one cycle after the request.
  - `cw_out` = 15'h0007.
  - Serial stream 1,1,1,0,...,0 over 15 cycles.
  - `write` high only on the 15th bit.
- `data1` = 11'h7FF via `req1` → `cw_out` = 15'h7FFF, all 15 serial bits 1. `data0` = 11'h000 → `cw_out` = 0.
- `req0` and `req1` both held continuously:
  - Grant order after reset is 0, 1, 0, 1.
  - Each `ack` pulses once.
  - Words are spaced 16 cycles apart.
- `en` dropped for 3 cycles at `cnt` = 5:
  - `ser_valid` low for those cycles, `cnt` holds at 5.
  - `write` arrives 3 cycles later than in the unstalled case.
  - The bit sequence is identical to the unstalled case.
- `reset` pulsed at `cnt` = 9:
  - All outputs go to 0 immediately; no `write` is produced.
  - The next request restarts at position 1.
- Checker for 200 random words:
  - Each word's 15 serial bits match `cw_out`.
  - The Hamming syndrome of `cw_out` is 0.
  - Flipping any single bit gives a syndrome equal to that bit's position.
